// File: rtl/grf_wport_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : grf_wport_arbiter_if
// Brief    : W-stage, LU handshake and GRF write-port bundle for the arbiter.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface grf_wport_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic [31:0] lu_pc;
  logic        wb_stall;
  logic        init_busy;
  logic        RFWr;
  logic [4:0]  A3;
  logic [31:0] WData;
  logic [31:0] WPC;

  modport master (
    output wb_we, wb_addr, wb_data, wb_pc,
    output lu_valid, lu_addr, lu_data, lu_pc,
    input  lu_ready, wb_stall, init_busy,
    input  RFWr, A3, WData, WPC
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, wb_pc,
    input  lu_valid, lu_addr, lu_data, lu_pc,
    output lu_ready, wb_stall, init_busy,
    output RFWr, A3, WData, WPC
  );
endinterface
`default_nettype wire

// File: rtl/grf_wport_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : grf_wport_arbiter
// Brief    : Shares the GRF write port between the W stage and a buffered LU
//            result path, with a post-reset zeroing sweep of $1..$31.
// Revision : 1.0
// ----------------------------------------------------------------------------
module grf_wport_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  grf_wport_arbiter_if.slave  bus
);

  localparam logic [3:0] c_max_wait = MAX_WAIT[3:0];
  localparam logic [4:0] c_last_reg = 5'd31;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [4:0]  r_init_ptr;
  logic        r_buf_full;
  logic [4:0]  r_buf_addr;
  logic [31:0] r_buf_data;
  logic [31:0] r_buf_pc;
  logic [3:0]  r_wait_cnt;

  logic        r_rfwr;
  logic [4:0]  r_a3;
  logic [31:0] r_wdata;
  logic [31:0] r_wpc;

  logic        w_init;
  logic        w_stall;
  logic        w_wb_req;
  logic        w_wb_grant;
  logic        w_lu_grant;
  logic        w_lu_ready;
  logic        w_lu_xfer;

  // A write to $0 never occupies the port.
  assign w_wb_req  = bus.wb_we && (bus.wb_addr != 5'd0);
  assign w_lu_xfer = bus.lu_valid && w_lu_ready;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_init       = 1'b0;
    w_stall      = 1'b0;
    w_wb_grant   = 1'b0;
    w_lu_grant   = 1'b0;
    w_lu_ready   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init  = 1'b1;
        w_stall = 1'b1;
        if (r_init_ptr == c_last_reg) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_stall = r_buf_full && (r_wait_cnt == c_max_wait);
        if (w_stall) begin
          w_lu_grant = 1'b1;
        end else if (w_wb_req) begin
          w_wb_grant = 1'b1;
        end else if (r_buf_full) begin
          w_lu_grant = 1'b1;
        end
        // Draining and refilling in one cycle keeps back-to-back LU at full rate.
        w_lu_ready = !r_buf_full || w_lu_grant;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_init_ptr <= 5'd1;
      r_buf_full <= 1'b0;
      r_buf_addr <= 5'd0;
      r_buf_data <= 32'd0;
      r_buf_pc   <= 32'd0;
      r_wait_cnt <= 4'd0;
      r_rfwr     <= 1'b0;
      r_a3       <= 5'd0;
      r_wdata    <= 32'd0;
      r_wpc      <= 32'd0;
    end else begin
      if (w_init && (r_init_ptr != c_last_reg)) begin
        r_init_ptr <= r_init_ptr + 5'd1;
      end

      if (w_lu_xfer) begin
        r_buf_full <= (bus.lu_addr != 5'd0);
        r_buf_addr <= bus.lu_addr;
        r_buf_data <= bus.lu_data;
        r_buf_pc   <= bus.lu_pc;
      end else if (w_lu_grant) begin
        r_buf_full <= 1'b0;
      end

      if (w_lu_grant || !r_buf_full) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != c_max_wait) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end

      if (w_init) begin
        r_rfwr  <= 1'b1;
        r_a3    <= r_init_ptr;
        r_wdata <= 32'd0;
        r_wpc   <= 32'd0;
      end else if (w_lu_grant) begin
        r_rfwr  <= 1'b1;
        r_a3    <= r_buf_addr;
        r_wdata <= r_buf_data;
        r_wpc   <= r_buf_pc;
      end else if (w_wb_grant) begin
        r_rfwr  <= 1'b1;
        r_a3    <= bus.wb_addr;
        r_wdata <= bus.wb_data;
        r_wpc   <= bus.wb_pc;
      end else begin
        r_rfwr  <= 1'b0;
        r_a3    <= 5'd0;
        r_wdata <= 32'd0;
        r_wpc   <= 32'd0;
      end
    end
  end

  assign bus.init_busy = w_init;
  assign bus.wb_stall  = w_stall;
  assign bus.lu_ready  = w_lu_ready;
  assign bus.RFWr      = r_rfwr;
  assign bus.A3        = r_a3;
  assign bus.WData     = r_wdata;
  assign bus.WPC       = r_wpc;

endmodule
`default_nettype wire
